// File: rtl/multiply_iter.sv
// Iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU/MULW) that consumes CHUNK multiplier bits per cycle.
// Optional early termination on an exhausted multiplier is enabled by defining MUL_EARLY_OUT_EN.
module multiply_iter #(
   parameter int XLEN  = 64,
   parameter int CHUNK = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            mul_valid_i,
   input  logic [XLEN-1:0] opr_a_i,
   input  logic [XLEN-1:0] opr_b_i,
   input  logic [3:0]      mul_func_i,
   input  logic            word_op_i,
   output logic            mul_ready_o,
   input  logic            mul_ready_i,
   output logic [XLEN-1:0] mul_res_o,
   output logic            mul_res_valid_o,
   input  logic            flush_i
);

   localparam logic [3:0] OP_MUL    = 4'd0;
   localparam logic [3:0] OP_MULH   = 4'd1;
   localparam logic [3:0] OP_MULHSU = 4'd2;
   localparam logic [3:0] OP_MULHU  = 4'd3;

   localparam int NDW = XLEN / CHUNK;
   localparam int NW  = 32 / CHUNK;
   localparam int CW  = $clog2(NDW) + 1;
   localparam logic [CW-1:0] LAST_DW = CW'(NDW - 1);
   localparam logic [CW-1:0] LAST_W  = CW'(NW - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2*XLEN-1:0]   a_sh_q, a_sh_d;
   logic [XLEN-1:0]     b_rem_q, b_rem_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                neg_q, neg_d;
   logic [3:0]          func_q, func_d;
   logic                word_q, word_d;

   logic                a_signed_s, b_signed_s;
   logic [2*XLEN-1:0]   pp_s;
   logic [XLEN-1:0]     b_next_s;
   logic                last_s, fin_s;
   logic [2*XLEN-1:0]   final_s;
   logic [XLEN-1:0]     res_s;

   // Magnitude as an unsigned XLEN value; word operands are negated in 32 bits, then zero-extended.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic is_signed,
                                                 input logic word);
      logic [31:0]     w;
      logic [XLEN-1:0] m;
      w = v[31:0];
      if (word) begin
         if (is_signed && w[31]) begin
            w = 32'd0 - w;
         end else begin
            w = v[31:0];
         end
         m = XLEN'(w);
      end else begin
         m = (is_signed && v[XLEN-1]) ? ({XLEN{1'b0}} - v) : v;
      end
      return m;
   endfunction

   function automatic logic sign_of(input logic [XLEN-1:0] v, input logic word);
      return word ? v[31] : v[XLEN-1];
   endfunction

   // Operand signedness for the incoming request.
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (mul_func_i)
         OP_MUL:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         OP_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         OP_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
         OP_MULHU:  begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
         default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      endcase
      if (word_op_i) begin
         a_signed_s = 1'b1;
         b_signed_s = 1'b1;
      end else begin
         a_signed_s = a_signed_s;
         b_signed_s = b_signed_s;
      end
   end

   // Final sign correction and result field selection.
   always_comb begin
      final_s = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
      case (func_q)
         OP_MUL:    res_s = word_q ? XLEN'($signed(final_s[31:0])) : final_s[XLEN-1:0];
         OP_MULH:   res_s = final_s[2*XLEN-1:XLEN];
         OP_MULHSU: res_s = final_s[2*XLEN-1:XLEN];
         OP_MULHU:  res_s = final_s[2*XLEN-1:XLEN];
         default:   res_s = final_s[XLEN-1:0];
      endcase
   end

   // Next-state and datapath: a_sh holds |a| pre-shifted to the current chunk position.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_rem_d  = b_rem_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      func_d   = func_q;
      word_d   = word_q;
      pp_s     = a_sh_q * {{(2*XLEN-CHUNK){1'b0}}, b_rem_q[CHUNK-1:0]};
      b_next_s = b_rem_q >> CHUNK;
      last_s   = (cnt_q == (word_q ? LAST_W : LAST_DW));
`ifdef MUL_EARLY_OUT_EN
      fin_s    = last_s | (b_next_s == {XLEN{1'b0}});
`else
      fin_s    = last_s;
`endif
      case (state_q)
         S_IDLE: begin
            if (mul_valid_i && !flush_i) begin
               state_d = S_RUN;
               a_sh_d  = {{XLEN{1'b0}}, magnitude(opr_a_i, a_signed_s, word_op_i)};
               b_rem_d = magnitude(opr_b_i, b_signed_s, word_op_i);
               acc_d   = {(2*XLEN){1'b0}};
               cnt_d   = {CW{1'b0}};
               neg_d   = (a_signed_s & sign_of(opr_a_i, word_op_i))
                       ^ (b_signed_s & sign_of(opr_b_i, word_op_i));
               func_d  = mul_func_i;
               word_d  = word_op_i;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d   = acc_q + pp_s;
               a_sh_d  = a_sh_q << CHUNK;
               b_rem_d = b_next_s;
               cnt_d   = cnt_q + CW'(1);
               state_d = fin_s ? S_DONE : S_RUN;
            end
         end
         S_DONE: begin
            if (flush_i || mul_ready_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         a_sh_q  <= {(2*XLEN){1'b0}};
         b_rem_q <= {XLEN{1'b0}};
         acc_q   <= {(2*XLEN){1'b0}};
         cnt_q   <= {CW{1'b0}};
         neg_q   <= 1'b0;
         func_q  <= 4'd0;
         word_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_rem_q <= b_rem_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         func_q  <= func_d;
         word_q  <= word_d;
      end
   end

   assign mul_ready_o     = (state_q == S_IDLE);
   assign mul_res_valid_o = (state_q == S_DONE) & ~flush_i;
   assign mul_res_o       = (state_q == S_DONE) ? res_s : {XLEN{1'b0}};

endmodule

// File: tb/tb_multiply_iter.sv
// Self-checking bench for multiply_iter (XLEN=64, CHUNK=16): directed table, corner sequences, random vs model.
module tb_multiply_iter;

   localparam logic [3:0] OP_MUL    = 4'd0;
   localparam logic [3:0] OP_MULH   = 4'd1;
   localparam logic [3:0] OP_MULHSU = 4'd2;
   localparam logic [3:0] OP_MULHU  = 4'd3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mul_valid_i;
   logic [63:0] opr_a_i;
   logic [63:0] opr_b_i;
   logic [3:0]  mul_func_i;
   logic        word_op_i;
   logic        mul_ready_o;
   logic        mul_ready_i;
   logic [63:0] mul_res_o;
   logic        mul_res_valid_o;
   logic        flush_i;

   int checks = 0;
   int errors = 0;

   multiply_iter #(.XLEN(64), .CHUNK(16)) dut (
      .clk(clk), .resetn(resetn), .mul_valid_i(mul_valid_i),
      .opr_a_i(opr_a_i), .opr_b_i(opr_b_i), .mul_func_i(mul_func_i),
      .word_op_i(word_op_i), .mul_ready_o(mul_ready_o), .mul_ready_i(mul_ready_i),
      .mul_res_o(mul_res_o), .mul_res_valid_o(mul_res_valid_o), .flush_i(flush_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference: full-width signed/unsigned product, then field selection.
   function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] f, input logic w);
      logic [127:0]       ea, eb, p;
      logic signed [63:0] pw;
      logic               as, bs;
      if (w) begin
         pw = $signed(a[31:0]) * $signed(b[31:0]);
         return {{32{pw[31]}}, pw[31:0]};
      end
      as = (f != OP_MULHU);
      bs = (f == OP_MUL) || (f == OP_MULH);
      ea = as ? {{64{a[63]}}, a} : {64'd0, a};
      eb = bs ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      return (f == OP_MUL) ? p[63:0] : p[127:64];
   endfunction

   // Reference latency: chunk count, shortened to the significant chunks of |b| when early-out is built in.
   function automatic int ref_lat(input logic [63:0] b, input logic [3:0] f, input logic w);
      int n;
      n = w ? 2 : 4;
`ifdef MUL_EARLY_OUT_EN
      begin
         logic signed [63:0] v;
         logic [63:0]        m;
         logic               bs;
         int                 need;
         v    = w ? 64'($signed(b[31:0])) : b;
         bs   = w || (f == OP_MUL) || (f == OP_MULH);
         m    = (bs && v[63]) ? (64'd0 - v) : v;
         need = 1;
         for (int k = 1; k < n; k++) begin
            if ((m >> (16 * k)) != 64'd0) need = k + 1;
         end
         n = need;
      end
`endif
      return n;
   endfunction

   // Issue one request from an idle DUT; returns the first valid result and cycles after the accepting edge.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                         input logic w, output logic [63:0] res, output int lat);
      mul_valid_i = 1'b1; opr_a_i = a; opr_b_i = b; mul_func_i = f; word_op_i = w;
      @(posedge clk); #1;
      mul_valid_i = 1'b0;
      opr_a_i = {$urandom, $urandom};
      opr_b_i = {$urandom, $urandom};
      mul_func_i = 4'($urandom_range(0, 3));
      word_op_i = 1'b0;
      lat = 0;
      while (mul_res_valid_o !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = mul_res_o;
   endtask

   task automatic handshake();
      mul_ready_i = 1'b1;
      @(posedge clk); #1;
      mul_ready_i = 1'b0;
   endtask

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  f;
      logic        w;
      logic [63:0] exp;
      int          lat_fixed;
      int          lat_early;
   } vec_t;

   vec_t        tbl[13];
   logic [63:0] res, exp_res;
   int          lat, exp_lat;
   logic        seen;

   initial begin
      tbl[0]  = '{64'd7, 64'hFFFFFFFFFFFFFFFD, OP_MUL, 1'b0, 64'hFFFFFFFFFFFFFFEB, 4, 1};
      tbl[1]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, OP_MULHU, 1'b0, 64'hFFFFFFFFFFFFFFFE, 4, 4};
      tbl[2]  = '{64'h8000000000000000, 64'h8000000000000000, OP_MULH, 1'b0, 64'h4000000000000000, 4, 4};
      tbl[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'd2, OP_MULHSU, 1'b0, 64'hFFFFFFFFFFFFFFFF, 4, 1};
      tbl[4]  = '{64'h000000007FFFFFFF, 64'd2, OP_MUL, 1'b1, 64'hFFFFFFFFFFFFFFFE, 2, 1};
      tbl[5]  = '{64'hDEADBEEF7FFFFFFF, 64'hDEADBEEF00000002, OP_MUL, 1'b1, 64'hFFFFFFFFFFFFFFFE, 2, 1};
      tbl[6]  = '{64'd3, 64'd5, OP_MUL, 1'b0, 64'd15, 4, 1};
      tbl[7]  = '{64'd9, 64'd3, OP_MUL, 1'b0, 64'd27, 4, 1};
      tbl[8]  = '{64'h00000000FFFFFFFF, 64'h0000000080000000, OP_MUL, 1'b1, 64'hFFFFFFFF80000000, 2, 2};
      tbl[9]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, OP_MULH, 1'b0, 64'd0, 4, 1};
      tbl[10] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, OP_MUL, 1'b0, 64'h8000000000000000, 4, 1};
      tbl[11] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, OP_MULHSU, 1'b0, 64'h8000000000000000, 4, 4};
      tbl[12] = '{64'd0, 64'd5, OP_MULHU, 1'b0, 64'd0, 4, 1};

      resetn = 1'b0; mul_valid_i = 1'b0; opr_a_i = 64'd0; opr_b_i = 64'd0;
      mul_func_i = 4'd0; word_op_i = 1'b0; mul_ready_i = 1'b0; flush_i = 1'b0;
      #12;
      chk("reset_ready", {63'd0, mul_ready_o}, 64'd1);
      chk("reset_valid", {63'd0, mul_res_valid_o}, 64'd0);
      chk("reset_res", mul_res_o, 64'd0);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
`ifdef MUL_EARLY_OUT_EN
         exp_lat = tbl[i].lat_early;
`else
         exp_lat = tbl[i].lat_fixed;
`endif
         run_op(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].w, res, lat);
         chk($sformatf("vec%0d_res", i), res, tbl[i].exp);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat));
         handshake();
         chk($sformatf("vec%0d_ready_after", i), {63'd0, mul_ready_o}, 64'd1);
      end

      // Consumer stalls five cycles: result and valid hold, unit stays busy.
      exp_res = ref_mul(64'h123456789ABCDEF0, 64'hFEDCBA9876543210, OP_MULHU, 1'b0);
      run_op(64'h123456789ABCDEF0, 64'hFEDCBA9876543210, OP_MULHU, 1'b0, res, lat);
      chk("stall_first_res", res, exp_res);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("stall_valid", {63'd0, mul_res_valid_o}, 64'd1);
         chk("stall_res", mul_res_o, exp_res);
         chk("stall_busy", {63'd0, mul_ready_o}, 64'd0);
      end
      handshake();
      chk("stall_ready_after", {63'd0, mul_ready_o}, 64'd1);
      chk("stall_valid_after", {63'd0, mul_res_valid_o}, 64'd0);
      chk("stall_res_after", mul_res_o, 64'd0);

      // Flush in the second RUN cycle, then an immediate new request.
      mul_valid_i = 1'b1; opr_a_i = 64'd11; opr_b_i = 64'hFFFF0000FFFF0000;
      mul_func_i = OP_MUL; word_op_i = 1'b0;
      @(posedge clk); #1; mul_valid_i = 1'b0;
      @(posedge clk); #1; flush_i = 1'b1;
      chk("flush_run_valid", {63'd0, mul_res_valid_o}, 64'd0);
      @(posedge clk); #1; flush_i = 1'b0;
      chk("flush_run_idle", {63'd0, mul_ready_o}, 64'd1);
      run_op(64'd3, 64'd5, OP_MUL, 1'b0, res, lat);
      chk("after_flush_res", res, 64'd15);
      chk("after_flush_lat", 64'(lat), 64'(ref_lat(64'd5, OP_MUL, 1'b0)));
      handshake();

      // Flush while the result is presented suppresses valid in the same cycle.
      run_op(64'd6, 64'd7, OP_MUL, 1'b0, res, lat);
      flush_i = 1'b1; #1;
      chk("flush_done_valid", {63'd0, mul_res_valid_o}, 64'd0);
      @(posedge clk); #1; flush_i = 1'b0;
      chk("flush_done_idle", {63'd0, mul_ready_o}, 64'd1);

      // Flush beats a simultaneous request.
      mul_valid_i = 1'b1; flush_i = 1'b1; opr_a_i = 64'd2; opr_b_i = 64'd2;
      @(posedge clk); #1; mul_valid_i = 1'b0; flush_i = 1'b0;
      chk("flush_accept_idle", {63'd0, mul_ready_o}, 64'd1);

      // Asynchronous reset mid-operation.
      mul_valid_i = 1'b1; opr_a_i = 64'd100; opr_b_i = 64'hFFFFFFFFFFFF0000; mul_func_i = OP_MUL;
      @(posedge clk); #1; mul_valid_i = 1'b0;
      @(posedge clk); #2; resetn = 1'b0; #1;
      chk("async_rst_ready", {63'd0, mul_ready_o}, 64'd1);
      chk("async_rst_valid", {63'd0, mul_res_valid_o}, 64'd0);
      chk("async_rst_res", mul_res_o, 64'd0);
      @(negedge clk); resetn = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (mul_res_valid_o === 1'b1) seen = 1'b1;
      end
      chk("no_result_after_reset", {63'd0, seen}, 64'd0);

      // Random operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [63:0] a, b;
         logic [3:0]  f;
         logic        w;
         f = 4'($urandom_range(0, 3));
         w = (f == OP_MUL) && ($urandom_range(0, 2) == 0);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: b = b & 64'h0000_0000_0000_FFFF;
            1: b = b | 64'h8000_0000_8000_0000;
            2: a = 64'h8000_0000_0000_0000;
            default: a = a;
         endcase
         exp_res = ref_mul(a, b, f, w);
         exp_lat = ref_lat(b, f, w);
         run_op(a, b, f, w, res, lat);
         chk($sformatf("rand%0d_res", i), res, exp_res);
         chk($sformatf("rand%0d_lat", i), 64'(lat), 64'(exp_lat));
         handshake();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
